// File: rtl/operand_fetch_if.sv
// Operand fetch bus: issue request, register file read port, writeback snoop, ALU operand handshake.
interface operand_fetch_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10,
    parameter int TAG_W  = 4
);
    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] issue_src_a;
    logic [ADDR_W-1:0] issue_src_b;
    logic [1:0]        issue_sel_a;
    logic [1:0]        issue_sel_b;
    logic [TAG_W-1:0]  issue_tag;

    logic [ADDR_W-1:0] rf_addr;
    logic [1:0]        rf_addr_sel;
    logic [DATA_W-1:0] rf_rdata;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [TAG_W-1:0]  op_tag;
    logic              op_err;

    modport slave (
        input  issue_valid, issue_src_a, issue_src_b, issue_sel_a, issue_sel_b, issue_tag,
        output issue_ready,
        output rf_addr, rf_addr_sel,
        input  rf_rdata,
        input  wb_valid, wb_addr, wb_data,
        output op_valid, op_a, op_b, op_tag, op_err,
        input  op_ready
    );

    modport master (
        output issue_valid, issue_src_a, issue_src_b, issue_sel_a, issue_sel_b, issue_tag,
        input  issue_ready,
        input  rf_addr, rf_addr_sel,
        output rf_rdata,
        output wb_valid, wb_addr, wb_data,
        input  op_valid, op_a, op_b, op_tag, op_err,
        output op_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: two sequential reads through a single RF read port, half-word extraction,
// writeback forwarding, and a valid/ready hand-off of the operand pair to the ALU.
module operand_fetch #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 10,
    parameter int NUM_REGS = 6,
    parameter int TAG_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    localparam int HALF_W = DATA_W / 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_A  = 3'd1;
    localparam logic [2:0] S_RD_B  = 3'd2;
    localparam logic [2:0] S_CAP_B = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d;
    logic [1:0]        sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic              fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [DATA_W-1:0] fwd_a_data_q, fwd_a_data_d, fwd_b_data_q, fwd_b_data_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic              err_a_q, err_a_d;
    logic              op_valid_q, op_valid_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [TAG_W-1:0]  op_tag_q, op_tag_d;
    logic              op_err_q, op_err_d;

    logic              wb_hit_a, wb_hit_b;
    logic [DATA_W-1:0] raw_a, raw_b;
    logic [DATA_W:0]   ext_a, ext_b;

    // Returns {err, operand}; out-of-range indices read as zero regardless of the RF data.
    function automatic logic [DATA_W:0] extract(input logic [DATA_W-1:0] w,
                                                input logic [1:0]        sel,
                                                input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] v;
        logic              err;
        err = 1'b0;
        case (sel)
            2'b00:   v = w;
            2'b01:   v = DATA_W'(w[DATA_W-1:HALF_W]);
            2'b10:   v = DATA_W'(w[HALF_W-1:0]);
            default: begin
                v   = w;
                err = 1'b1;
            end
        endcase
        if (idx >= ADDR_W'(NUM_REGS)) begin
            v   = '0;
            err = 1'b1;
        end
        return {err, v};
    endfunction

    // A write in the capture cycle is newer than one recorded during the address cycle.
    assign wb_hit_a = bus.wb_valid && (bus.wb_addr == src_a_q);
    assign wb_hit_b = bus.wb_valid && (bus.wb_addr == src_b_q);
    assign raw_a    = wb_hit_a ? bus.wb_data : (fwd_a_q ? fwd_a_data_q : bus.rf_rdata);
    assign raw_b    = wb_hit_b ? bus.wb_data : (fwd_b_q ? fwd_b_data_q : bus.rf_rdata);
    assign ext_a    = extract(raw_a, sel_a_q, src_a_q);
    assign ext_b    = extract(raw_b, sel_b_q, src_b_q);

    always_comb begin
        state_d      = state_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        sel_a_d      = sel_a_q;
        sel_b_d      = sel_b_q;
        tag_d        = tag_q;
        rf_addr_d    = rf_addr_q;
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;
        fwd_a_data_d = fwd_a_data_q;
        fwd_b_data_d = fwd_b_data_q;
        a_d          = a_q;
        err_a_d      = err_a_q;
        op_valid_d   = op_valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_tag_d     = op_tag_q;
        op_err_d     = op_err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.issue_valid) begin
                    src_a_d   = bus.issue_src_a;
                    src_b_d   = bus.issue_src_b;
                    sel_a_d   = bus.issue_sel_a;
                    sel_b_d   = bus.issue_sel_b;
                    tag_d     = bus.issue_tag;
                    rf_addr_d = bus.issue_src_a;
                    state_d   = S_RD_A;
                end
            end
            S_RD_A: begin
                // The RF samples src_a at the end of this cycle and misses a same-edge write.
                rf_addr_d    = src_b_q;
                fwd_a_d      = wb_hit_a;
                fwd_a_data_d = bus.wb_data;
                state_d      = S_RD_B;
            end
            S_RD_B: begin
                a_d          = ext_a[DATA_W-1:0];
                err_a_d      = ext_a[DATA_W];
                fwd_b_d      = wb_hit_b;
                fwd_b_data_d = bus.wb_data;
                state_d      = S_CAP_B;
            end
            S_CAP_B: begin
                op_a_d     = a_q;
                op_b_d     = ext_b[DATA_W-1:0];
                op_err_d   = err_a_q | ext_b[DATA_W];
                op_tag_d   = tag_q;
                op_valid_d = 1'b1;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (bus.op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_a_q      <= '0;
            src_b_q      <= '0;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            tag_q        <= '0;
            rf_addr_q    <= '0;
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            fwd_a_data_q <= '0;
            fwd_b_data_q <= '0;
            a_q          <= '0;
            err_a_q      <= 1'b0;
            op_valid_q   <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_tag_q     <= '0;
            op_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
            tag_q        <= tag_d;
            rf_addr_q    <= rf_addr_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            fwd_a_data_q <= fwd_a_data_d;
            fwd_b_data_q <= fwd_b_data_d;
            a_q          <= a_d;
            err_a_q      <= err_a_d;
            op_valid_q   <= op_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_tag_q     <= op_tag_d;
            op_err_q     <= op_err_d;
        end
    end

    assign bus.issue_ready = (state_q == S_IDLE);
    assign bus.rf_addr     = rf_addr_q;
    assign bus.rf_addr_sel = 2'b00;
    assign bus.op_valid    = op_valid_q;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.op_tag      = op_tag_q;
    assign bus.op_err      = op_err_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural register file plus a reference that derives each operand
// from the architectural register contents at that operand's capture edge.
module tb_operand_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file: one-cycle registered read, read-before-write on a same-edge write.
    logic [19:0] mem [6];
    always @(posedge clk) begin
        bus.rf_rdata <= (bus.rf_addr < 10'd6) ? mem[bus.rf_addr[2:0]] : 20'hBADBA;
        if (bus.wb_valid && bus.wb_addr < 10'd6) mem[bus.wb_addr[2:0]] <= bus.wb_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {err, operand} for a register's current architectural value.
    function automatic logic [20:0] ref_op(input logic [9:0] idx, input logic [1:0] sel);
        logic [19:0] w;
        if (idx >= 10'd6) return {1'b1, 20'd0};
        w = mem[idx[2:0]];
        case (sel)
            2'd0:    return {1'b0, w};
            2'd1:    return {1'b0, w / 20'd1024};
            2'd2:    return {1'b0, w % 20'd1024};
            default: return {1'b1, w};
        endcase
    endfunction

    task automatic drive_wb(input bit force_it, input logic [9:0] a, input logic [19:0] d,
                            input bit rnd, input logic [9:0] sa, input logic [9:0] sb);
        if (force_it) begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = a;
            bus.wb_data  = d;
        end else if (rnd && $urandom_range(0, 1) == 1) begin
            bus.wb_valid = 1'b1;
            case ($urandom_range(0, 2))
                0:       bus.wb_addr = sa;
                1:       bus.wb_addr = sb;
                default: bus.wb_addr = 10'($urandom_range(0, 7));
            endcase
            bus.wb_data = 20'($urandom);
        end else begin
            bus.wb_valid = 1'b0;
        end
    endtask

    task automatic garbage_issue();
        bus.issue_valid = 1'($urandom);
        bus.issue_src_a = 10'($urandom_range(0, 7));
        bus.issue_src_b = 10'($urandom_range(0, 7));
        bus.issue_sel_a = 2'($urandom);
        bus.issue_sel_b = 2'($urandom);
        bus.issue_tag   = 4'($urandom);
    endtask

    task automatic wr(input logic [9:0] a, input logic [19:0] d);
        drive_wb(1'b1, a, d, 1'b0, '0, '0);
        @(negedge clk);
        bus.wb_valid = 1'b0;
    endtask

    // Entered and left at a negedge with the DUT idle. wcyc picks the cycle (0 issue, 1 RD_A,
    // 2 RD_B, 3 CAP_B) of one directed writeback; stall is the number of op_ready-low HOLD cycles.
    task automatic run_op(input logic [9:0] sa, input logic [1:0] sla, input logic [9:0] sb,
                          input logic [1:0] slb, input logic [3:0] tg, input int wcyc,
                          input logic [9:0] waddr, input logic [19:0] wdata, input bit rnd,
                          input int stall);
        logic [20:0] ra, rb;
        ra = '0;
        rb = '0;
        chk("idle_ready", bus.issue_ready, 1);
        bus.op_ready    = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_src_a = sa;
        bus.issue_src_b = sb;
        bus.issue_sel_a = sla;
        bus.issue_sel_b = slb;
        bus.issue_tag   = tg;
        for (int c = 0; c < 4; c++) begin
            drive_wb(c == wcyc, waddr, wdata, rnd, sa, sb);
            @(negedge clk);
            garbage_issue();
            chk("busy_ready", bus.issue_ready, 0);
            if (c < 3) chk("early_valid", bus.op_valid, 0);
            if (c == 0) chk("rf_addr_a", bus.rf_addr, sa);
            if (c == 1) chk("rf_addr_b", bus.rf_addr, sb);
            if (c == 2) ra = ref_op(sa, sla);
            if (c == 3) rb = ref_op(sb, slb);
        end
        for (int s = 0; s <= stall; s++) begin
            chk("op_valid", bus.op_valid, 1);
            chk("op_a", bus.op_a, ra[19:0]);
            chk("op_b", bus.op_b, rb[19:0]);
            chk("op_tag", bus.op_tag, tg);
            chk("op_err", bus.op_err, ra[20] | rb[20]);
            chk("hold_ready", bus.issue_ready, 0);
            chk("rf_addr_sel", bus.rf_addr_sel, 0);
            if (s == stall) bus.op_ready = 1'b1;
            drive_wb(1'b0, '0, '0, 1'b1, sa, sb);
            @(negedge clk);
            garbage_issue();
        end
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.op_ready    = 1'($urandom);
        chk("post_valid", bus.op_valid, 0);
        chk("post_ready", bus.issue_ready, 1);
    endtask

    logic [9:0]  r_sa, r_sb;
    logic [1:0]  r_sla, r_slb;
    logic [3:0]  r_tg;
    int          r_wc;

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_src_a = '0;
        bus.issue_src_b = '0;
        bus.issue_sel_a = '0;
        bus.issue_sel_b = '0;
        bus.issue_tag   = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.op_ready    = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_issue_ready", bus.issue_ready, 1);
        chk("rst_op_valid", bus.op_valid, 0);
        chk("rst_op_a", bus.op_a, 0);
        chk("rst_op_b", bus.op_b, 0);
        chk("rst_op_tag", bus.op_tag, 0);
        chk("rst_op_err", bus.op_err, 0);
        chk("rst_rf_addr", bus.rf_addr, 0);
        chk("rst_rf_addr_sel", bus.rf_addr_sel, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) wr(10'(i), 20'($urandom));

        // Full word and high half
        wr(10'd0, 20'hAAAAA);
        wr(10'd1, 20'hCCCCC);
        run_op(10'd0, 2'b00, 10'd1, 2'b01, 4'd3, -1, '0, '0, 1'b0, 0);

        // Low half and out-of-range index
        wr(10'd2, 20'hF0F0F);
        run_op(10'd2, 2'b10, 10'd7, 2'b00, 4'd9, -1, '0, '0, 1'b0, 0);

        // Reserved select
        run_op(10'd1, 2'b11, 10'd0, 2'b00, 4'd1, -1, '0, '0, 1'b0, 0);

        // Forwarding: a capture cycle, a address cycle, b address cycle, b capture cycle
        wr(10'd4, 20'h12345);
        run_op(10'd4, 2'b00, 10'd5, 2'b00, 4'd4, 2, 10'd4, 20'h54321, 1'b0, 0);
        run_op(10'd3, 2'b00, 10'd5, 2'b00, 4'd5, 1, 10'd3, 20'h0BEEF, 1'b0, 0);
        run_op(10'd3, 2'b01, 10'd5, 2'b00, 4'd6, 2, 10'd5, 20'h7A5A5, 1'b0, 0);
        run_op(10'd2, 2'b00, 10'd5, 2'b10, 4'd7, 3, 10'd5, 20'hFFC01, 1'b0, 0);

        // Same source twice, with a six-cycle stall and writebacks during HOLD
        run_op(10'd1, 2'b00, 10'd1, 2'b10, 4'd8, -1, '0, '0, 1'b0, 6);

        // Reset in RD_B discards the fetch
        bus.issue_valid = 1'b1;
        bus.issue_src_a = 10'd1;
        bus.issue_src_b = 10'd2;
        bus.issue_sel_a = 2'b00;
        bus.issue_sel_b = 2'b00;
        bus.issue_tag   = 4'd5;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_issue_ready", bus.issue_ready, 1);
        chk("mid_rst_op_valid", bus.op_valid, 0);
        chk("mid_rst_op_a", bus.op_a, 0);
        chk("mid_rst_op_b", bus.op_b, 0);
        chk("mid_rst_op_tag", bus.op_tag, 0);
        chk("mid_rst_rf_addr", bus.rf_addr, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_quiet", bus.op_valid, 0);
        end
        run_op(10'd0, 2'b00, 10'd4, 2'b01, 4'd2, -1, '0, '0, 1'b0, 0);

        // Randomized traffic with random writebacks and stalls
        for (int t = 0; t < 50; t++) begin
            r_sa  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(6, 1023)) : 10'($urandom_range(0, 5));
            r_sb  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(6, 1023)) : 10'($urandom_range(0, 5));
            r_sla = 2'($urandom);
            r_slb = 2'($urandom);
            r_tg  = 4'($urandom);
            r_wc  = $urandom_range(0, 4);
            run_op(r_sa, r_sla, r_sb, r_slb, r_tg, r_wc, r_sb, 20'($urandom), 1'b1,
                   $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
